mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master burst arbiter in front of a single SDRAM controller port.
// Optional macro ARB_FIXED_PRIO_EN: ties always go to master 0 instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wren,
    input  logic              m1_wren,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m0_to_mem,
    input  logic [DATA_W-1:0] m1_to_mem,
    output logic              m0_ready,
    output logic              m1_ready,
    output logic [1:0]        m0_offset,
    output logic [1:0]        m1_offset,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_to_mem,
    input  logic              mem_ready,
    input  logic [1:0]        mem_offset,
    output logic [CNT_W-1:0]  grant_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             w_last_grant_nxt;
    logic [CNT_W-1:0] r_grant_count;
    logic             w_grant_inc;
    logic             w_burst_end;
    logic             w_tie_pick1;

    assign w_burst_end = mem_ready && (mem_offset == 2'd3);

`ifdef ARB_FIXED_PRIO_EN
    assign w_tie_pick1 = 1'b0;
`else
    assign w_tie_pick1 = ~r_last_grant;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_grant_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            if (w_grant_inc) begin
                r_grant_count <= r_grant_count + 1'b1;
            end
        end
    end

    // Grants are only issued from IDLE, so a request seen on the burst-end
    // cycle waits one IDLE cycle before it can win.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_grant_inc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m0_req && m1_req) begin
                    w_state_nxt      = w_tie_pick1 ? S_GNT1 : S_GNT0;
                    w_last_grant_nxt = w_tie_pick1;
                    w_grant_inc      = 1'b1;
                end else if (m0_req) begin
                    w_state_nxt      = S_GNT0;
                    w_last_grant_nxt = 1'b0;
                    w_grant_inc      = 1'b1;
                end else if (m1_req) begin
                    w_state_nxt      = S_GNT1;
                    w_last_grant_nxt = 1'b1;
                    w_grant_inc      = 1'b1;
                end
            end
            S_GNT0, S_GNT1: begin
                if (w_burst_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_wren    = 1'b0;
        mem_address = m0_address;
        mem_to_mem  = m0_to_mem;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_offset   = 2'd0;
        m1_offset   = 2'd0;
        case (r_state)
            S_GNT0: begin
                mem_req   = m0_req;
                mem_wren  = m0_wren;
                m0_ready  = mem_ready;
                m0_offset = mem_offset;
            end
            S_GNT1: begin
                mem_req     = m1_req;
                mem_wren    = m1_wren;
                mem_address = m1_address;
                mem_to_mem  = m1_to_mem;
                m1_ready    = mem_ready;
                m1_offset   = mem_offset;
            end
            default: ;
        endcase
    end

    assign grant_count = r_grant_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations follow ARB_FIXED_PRIO_EN.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req;
    logic        m0_wren, m1_wren;
    logic [23:0] m0_address, m1_address;
    logic [15:0] m0_to_mem, m1_to_mem;
    logic        m0_ready, m1_ready;
    logic [1:0]  m0_offset, m1_offset;
    logic        mem_req, mem_wren;
    logic [23:0] mem_address;
    logic [15:0] mem_to_mem;
    logic        mem_ready;
    logic [1:0]  mem_offset;
    logic [15:0] grant_count;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .m0_wren     (m0_wren),
        .m1_wren     (m1_wren),
        .m0_address  (m0_address),
        .m1_address  (m1_address),
        .m0_to_mem   (m0_to_mem),
        .m1_to_mem   (m1_to_mem),
        .m0_ready    (m0_ready),
        .m1_ready    (m1_ready),
        .m0_offset   (m0_offset),
        .m1_offset   (m1_offset),
        .mem_req     (mem_req),
        .mem_wren    (mem_wren),
        .mem_address (mem_address),
        .mem_to_mem  (mem_to_mem),
        .mem_ready   (mem_ready),
        .mem_offset  (mem_offset),
        .grant_count (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives four ready words at offsets 0..3 for the granted master m.
    // At word drop_at the master lowers its request (4 = never).
    task automatic run_burst(input int m, input int drop_at);
        for (int k = 0; k < 4; k++) begin
            mem_ready  = 1'b1;
            mem_offset = 2'(k);
            if (k == drop_at) begin
                if (m == 0) m0_req = 1'b0;
                else        m1_req = 1'b0;
            end
            #1;
            chk("rdy_granted",  (m == 0) ? m0_ready  : m1_ready,  1);
            chk("off_granted",  (m == 0) ? m0_offset : m1_offset, k);
            chk("rdy_other",    (m == 0) ? m1_ready  : m0_ready,  0);
            chk("off_other",    (m == 0) ? m1_offset : m0_offset, 0);
            chk("mem_req_burst", mem_req, (k < drop_at) ? 1 : 0);
            tick();
        end
        mem_ready  = 1'b0;
        mem_offset = 2'd0;
    endtask

    initial begin
        int exp_m;
        rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b0;
        m0_wren = 1'b0; m1_wren = 1'b0;
        m0_address = 24'h0ABC00; m1_address = 24'h123450;
        m0_to_mem = 16'h1111; m1_to_mem = 16'hBEEF;
        mem_ready = 1'b1; mem_offset = 2'd2;
        #12;
        // Reset state with request and ready glitch present
        chk("rst_mem_req",  mem_req,     0);
        chk("rst_mem_wren", mem_wren,    0);
        chk("rst_m0_ready", m0_ready,    0);
        chk("rst_m1_ready", m1_ready,    0);
        chk("rst_m0_off",   m0_offset,   0);
        chk("rst_m1_off",   m1_offset,   0);
        chk("rst_count",    grant_count, 0);

        tick();
        rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b1; m1_wren = 1'b1;
        mem_ready = 1'b0; mem_offset = 2'd0;
        #1;
        chk("idle_no_req_yet", mem_req, 0);
        tick();
        chk("g1_mem_req",  mem_req,     1);
        chk("g1_addr",     mem_address, 24'h123450);
        chk("g1_wren",     mem_wren,    1);
        chk("g1_data",     mem_to_mem,  16'hBEEF);
        chk("g1_count",    grant_count, 1);
        run_burst(1, 4);
        m1_req = 1'b0; m1_wren = 1'b0;
        #1;
        chk("g1_end_req", mem_req, 0);

        // Ready glitch while IDLE must not reach either master or end anything
        tick();
        mem_ready = 1'b1; mem_offset = 2'd3;
        #1;
        chk("glitch_m0_ready", m0_ready, 0);
        chk("glitch_m1_ready", m1_ready, 0);
        tick();
        chk("glitch_count", grant_count, 1);
        chk("glitch_req",   mem_req,     0);
        mem_ready = 1'b0; mem_offset = 2'd0;

        // Both masters held high for four bursts
        m0_address = 24'h000100; m1_address = 24'h000200;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_m = 0;
`else
            exp_m = i % 2;
`endif
            tick();
            chk("tie_req",   mem_req,     1);
            chk("tie_addr",  mem_address, (exp_m == 1) ? 24'h000200 : 24'h000100);
            chk("tie_count", grant_count, 2 + i);
            run_burst(exp_m, 4);
            #1;
            chk("tie_gap_req", mem_req, 0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Master 0 drops its request mid-burst; grant is held to offset 3
        m0_req = 1'b1;
        tick();
        chk("drop_count", grant_count, 6);
        run_burst(0, 2);
        #1;
        chk("drop_idle_req", mem_req, 0);
        tick();
        chk("drop_no_regrant", grant_count, 6);

        // Reset in the middle of a master 0 burst
        m0_req = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b1; mem_offset = 2'(k);
            tick();
        end
        mem_offset = 2'd2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req",   mem_req,     0);
        chk("mid_rst_ready", m0_ready,    0);
        chk("mid_rst_off",   m0_offset,   0);
        chk("mid_rst_count", grant_count, 0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b0; mem_offset = 2'd0;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        chk("post_rst_addr",  mem_address, 24'h000100);
        chk("post_rst_m1rdy", m1_ready,    0);
        chk("post_rst_count", grant_count, 1);
        run_burst(0, 4);
        m0_req = 1'b0; m1_req = 1'b1;
        #1;
        chk("post_rst_gap", mem_req, 0);
        m1_req = 1'b0;
        tick();

        // Counter wrap: preload to the last value, then one more grant
        force dut.r_grant_count = 16'hFFFF;
        tick();
        release dut.r_grant_count;
        m1_req = 1'b1;
        tick();
        chk("wrap_zero", grant_count, 16'h0000);
        run_burst(1, 4);
        m1_req = 1'b0;
        m0_req = 1'b1;
        tick();
        chk("wrap_next", grant_count, 16'h0001);
        run_burst(0, 4);
        m0_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
